// File: rtl/sc_input_feeder.sv
// sc_input_feeder: upstream feeder for the SODA_2d 3x3 stencil core.
//   Accepts a serial valid/ready stream of BW-bit words: first ST*ST kernel
//   weights, then ROW*COL pixels in row-major order. Pixels are packed into
//   ST-wide beats and strobed into the core, which has no backpressure, so
//   this block owns all frame sequencing and flow control.
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-low reset
//   start        in   one-cycle frame start pulse (honoured only in IDLE)
//   s_valid      in   upstream element valid
//   s_data       in   upstream element (BW bits)
//   s_ready      out  element accepted when s_valid && s_ready
//   sc_in_ready  out  beat strobe to core io_in_ready
//   sc_in_matrix out  packed beat (ST*BW), column 0 of a group in the MSB slot
//   sc_in_weight out  packed kernel (ST*ST*BW), first weight in the MSB slot
//   busy         out  high while loading weights or streaming pixels
//   done         out  one-cycle pulse at frame end
module sc_input_feeder #(
    parameter int BW  = 32,
    parameter int ST  = 3,
    parameter int ROW = 8,
    parameter int COL = 9
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 s_valid,
    input  logic [BW-1:0]        s_data,
    output logic                 s_ready,
    output logic                 sc_in_ready,
    output logic [ST*BW-1:0]     sc_in_matrix,
    output logic [ST*ST*BW-1:0]  sc_in_weight,
    output logic                 busy,
    output logic                 done
);
    localparam int NB   = COL / ST;
    localparam int NW   = ST * ST;
    localparam int EW   = (ST > 1) ? $clog2(ST) : 1;
    localparam int BCW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int RW   = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int WW   = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [EW-1:0]  ELEM_LAST = EW'(ST - 1);
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(NB - 1);
    localparam logic [RW-1:0]  ROW_LAST  = RW'(ROW - 1);
    localparam logic [WW-1:0]  W_LAST    = WW'(NW - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DONE} state_t;

    state_t                r_state, w_next;
    logic [EW-1:0]         r_elem;
    logic [BCW-1:0]        r_beat_cnt;
    logic [RW-1:0]         r_row;
    logic [WW-1:0]         r_wcnt;
    logic [ST*BW-1:0]      r_pack;
    logic [ST*BW-1:0]      r_matrix;
    logic [ST*ST*BW-1:0]   r_weight;
    logic                  r_full;
    logic                  r_ready;
    logic                  r_drain;
    logic                  r_end;
    logic                  w_start;
    logic                  w_wgt;
    logic                  w_pix;
    logic                  w_beat_done;
    logic                  w_row_done;
    logic                  w_frame_end;

    assign sc_in_ready  = r_ready;
    assign sc_in_matrix = r_matrix;
    assign sc_in_weight = r_weight;

    assign w_start     = (r_state == S_IDLE) && start;
    assign w_wgt       = s_valid && s_ready && (r_state == S_LOAD_W);
    assign w_pix       = s_valid && s_ready && (r_state == S_STREAM);
    assign w_beat_done = w_pix && (r_elem == ELEM_LAST);
    assign w_row_done  = w_beat_done && (r_beat_cnt == BEAT_LAST);
    assign w_frame_end = w_row_done && (r_row == ROW_LAST);

    always_ff @(posedge clock) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // r_drain closes s_ready once the final pixel is in, while the last beat
    // is still travelling through the two-stage strobe pipeline.
    always_comb begin
        w_next  = r_state;
        s_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (r_state)
            S_IDLE:   w_next = start ? S_LOAD_W : S_IDLE;
            S_LOAD_W: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                w_next  = (s_valid && r_wcnt == W_LAST) ? S_STREAM : S_LOAD_W;
            end
            S_STREAM: begin
                s_ready = !r_drain;
                busy    = 1'b1;
                w_next  = r_end ? S_DONE : S_STREAM;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    // A completed beat sits in r_pack for one cycle (r_full), then moves to
    // r_matrix together with the strobe. r_end marks that strobe as the
    // frame's last, which moves the FSM to DONE on the following edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_elem     <= '0;
            r_beat_cnt <= '0;
            r_row      <= '0;
            r_wcnt     <= '0;
            r_pack     <= '0;
            r_matrix   <= '0;
            r_weight   <= '0;
            r_full     <= 1'b0;
            r_ready    <= 1'b0;
            r_drain    <= 1'b0;
            r_end      <= 1'b0;
        end else begin
            if (w_start) begin
                r_elem     <= '0;
                r_beat_cnt <= '0;
                r_row      <= '0;
                r_wcnt     <= '0;
            end
            if (w_wgt)
                r_wcnt <= (r_wcnt == W_LAST) ? '0 : r_wcnt + 1'b1;
            for (int i = 0; i < NW; i++)
                if (w_wgt && r_wcnt == WW'(i))
                    r_weight[(NW-i)*BW-1 -: BW] <= s_data;
            if (w_pix) begin
                r_elem <= w_beat_done ? '0 : r_elem + 1'b1;
                if (w_beat_done)
                    r_beat_cnt <= w_row_done ? '0 : r_beat_cnt + 1'b1;
                if (w_row_done)
                    r_row <= w_frame_end ? '0 : r_row + 1'b1;
            end
            for (int i = 0; i < ST; i++)
                if (w_pix && r_elem == EW'(i))
                    r_pack[(ST-i)*BW-1 -: BW] <= s_data;
            r_drain  <= w_start ? 1'b0 : (r_drain | w_frame_end);
            r_full   <= w_beat_done;
            r_ready  <= r_full;
            r_matrix <= r_full ? r_pack : r_matrix;
            r_end    <= r_full & r_drain;
        end
    end
endmodule
